// File: rtl/riscv_alu_pc_adders.sv
// Execute-side arithmetic cluster: RV32I ALU, fetch PC incrementer, stage-4 link adder.
// Optional multiplier on alusel=11 is enabled by defining ALU_MUL_EN.
module riscv_alu_pc_adders (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [3:0]  alusel,
    output logic [31:0] rd,
    output logic [31:0] alu_q,
    input  logic [31:0] pc,
    input  logic        en,
    output logic [31:0] pcinc,
    input  logic [31:0] pc3,
    output logic [31:0] pc3new
);

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SLL   = 4'd2,
        OP_SLT   = 4'd3,
        OP_SLTU  = 4'd4,
        OP_XOR   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_OR    = 4'd8,
        OP_AND   = 4'd9,
        OP_PASSB = 4'd10,
        OP_MUL   = 4'd11
    } alu_op_t;

    logic [4:0]  shamt;
    logic        lt_signed;
    logic        lt_unsigned;
    logic [31:0] mul_lo;

    assign shamt       = rs2[4:0];
    assign lt_signed   = $signed(rs1) < $signed(rs2);
    assign lt_unsigned = rs1 < rs2;

`ifdef ALU_MUL_EN
    // Low word of the product is identical for signed and unsigned operands.
    assign mul_lo = rs1 * rs2;
`else
    assign mul_lo = 32'd0;
`endif

    always_comb begin
        rd = 32'd0;
        case (alu_op_t'(alusel))
            OP_ADD:   rd = rs1 + rs2;
            OP_SUB:   rd = rs1 - rs2;
            OP_SLL:   rd = rs1 << shamt;
            OP_SLT:   rd = {31'd0, lt_signed};
            OP_SLTU:  rd = {31'd0, lt_unsigned};
            OP_XOR:   rd = rs1 ^ rs2;
            OP_SRL:   rd = rs1 >> shamt;
            OP_SRA:   rd = $unsigned($signed(rs1) >>> shamt);
            OP_OR:    rd = rs1 | rs2;
            OP_AND:   rd = rs1 & rs2;
            OP_PASSB: rd = rs2;
            OP_MUL:   rd = mul_lo;
            default:  rd = 32'd0;
        endcase
    end

    // A stall holds the fetch PC by presenting it unchanged.
    assign pcinc  = en ? (pc + 32'd4) : pc;
    assign pc3new = pc3 + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_q <= 32'd0;
        end else begin
            alu_q <= rd;
        end
    end

endmodule

// File: tb/tb_riscv_alu_pc_adders.sv
// Directed bench for riscv_alu_pc_adders: expected values queued by the driver,
// compared by a monitor when each sample strobe fires.
module tb_riscv_alu_pc_adders;

    logic        clk;
    logic        rst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  alusel;
    logic [31:0] rd;
    logic [31:0] alu_q;
    logic [31:0] pc;
    logic        en;
    logic [31:0] pcinc;
    logic [31:0] pc3;
    logic [31:0] pc3new;

    riscv_alu_pc_adders dut (
        .clk    (clk),
        .rst    (rst),
        .rs1    (rs1),
        .rs2    (rs2),
        .alusel (alusel),
        .rd     (rd),
        .alu_q  (alu_q),
        .pc     (pc),
        .en     (en),
        .pcinc  (pcinc),
        .pc3    (pc3),
        .pc3new (pc3new)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [31:0] exp_q[$];
    logic [1:0]  which_q[$];
    string       name_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    event        sample_ev;

    // Monitor: 0=rd, 1=pcinc, 2=pc3new, 3=alu_q
    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                logic [31:0] exp_v;
                logic [31:0] act_v;
                logic [1:0]  w;
                string       nm;
                exp_v = exp_q.pop_front();
                w     = which_q.pop_front();
                nm    = name_q.pop_front();
                case (w)
                    2'd0:    act_v = rd;
                    2'd1:    act_v = pcinc;
                    2'd2:    act_v = pc3new;
                    default: act_v = alu_q;
                endcase
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act_v, exp_v);
                end
            end
        end
    end

    // Driver tasks
    task automatic expect_out(input logic [1:0] w, input logic [31:0] e, input string nm);
        exp_q.push_back(e);
        which_q.push_back(w);
        name_q.push_back(nm);
        -> sample_ev;
        #1;
    endtask

    task automatic alu_vec(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                           input logic [31:0] e, input string nm);
        rs1 = a;
        rs2 = b;
        alusel = s;
        #1;
        expect_out(2'd0, e, nm);
    endtask

    task automatic pc_vec(input logic [31:0] p, input logic e_n, input logic [31:0] e, input string nm);
        pc = p;
        en = e_n;
        #1;
        expect_out(2'd1, e, nm);
    endtask

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mul_exp;
        logic [31:0] ma;
        logic [31:0] mb;
        rst = 1'b1;
        rs1 = 32'd0;
        rs2 = 32'd0;
        alusel = 4'd0;
        pc = 32'd0;
        en = 1'b0;
        pc3 = 32'd0;
        @(negedge clk);

        // Combinational paths, exercised while reset is held
        alu_vec(32'hFFFFFFFF, 32'd1, 4'd0, 32'd0, "add_wrap");
        alu_vec(32'd0, 32'd1, 4'd1, 32'hFFFFFFFF, "sub_wrap");
        alu_vec(32'd100, 32'd23, 4'd0, 32'd123, "add_plain");
        alu_vec(32'd100, 32'd23, 4'd1, 32'd77, "sub_plain");
        alu_vec(32'hFFFFFFFF, 32'd1, 4'd3, 32'd1, "slt_neg");
        alu_vec(32'hFFFFFFFF, 32'd1, 4'd4, 32'd0, "sltu_big");
        alu_vec(32'd1, 32'hFFFFFFFF, 4'd4, 32'd1, "sltu_small");
        alu_vec(32'd5, 32'd5, 4'd3, 32'd0, "slt_equal");
        alu_vec(32'h80000000, 32'h21, 4'd6, 32'h40000000, "srl_amt1");
        alu_vec(32'h80000000, 32'h21, 4'd7, 32'hC0000000, "sra_amt1");
        alu_vec(32'd1, 32'h21, 4'd2, 32'd2, "sll_amt1");
        alu_vec(32'h80000000, 32'h1F, 4'd7, 32'hFFFFFFFF, "sra_amt31");
        alu_vec(32'h70000000, 32'h4, 4'd7, 32'h07000000, "sra_pos");
        alu_vec(32'h12345678, 32'h20, 4'd2, 32'h12345678, "sll_amt0");
        alu_vec(32'hF0F0F0F0, 32'h0FF00FF0, 4'd5, 32'hFF00FF00, "xor");
        alu_vec(32'hF0F0F0F0, 32'h0FF00FF0, 4'd8, 32'hFFF0FFF0, "or");
        alu_vec(32'hF0F0F0F0, 32'h0FF00FF0, 4'd9, 32'h00F000F0, "and");
        alu_vec(32'hF0F0F0F0, 32'h0FF00FF0, 4'd10, 32'h0FF00FF0, "passb");
        alu_vec(32'hF0F0F0F0, 32'h0FF00FF0, 4'd12, 32'd0, "sel12");
        alu_vec(32'hF0F0F0F0, 32'h0FF00FF0, 4'd14, 32'd0, "sel14");
        alu_vec(32'hF0F0F0F0, 32'h0FF00FF0, 4'd15, 32'd0, "sel15");
        ma = 32'hF0F0F0F0;
        mb = 32'h0FF00FF0;
`ifdef ALU_MUL_EN
        mul_exp = ma * mb;
`else
        mul_exp = 32'd0;
`endif
        alu_vec(ma, mb, 4'd11, mul_exp, "mul");

        pc_vec(32'h100, 1'b1, 32'h104, "pcinc_en");
        pc_vec(32'h100, 1'b0, 32'h100, "pcinc_stall");
        pc_vec(32'hFFFFFFFC, 1'b1, 32'd0, "pcinc_wrap");
        pc_vec(32'hFFFFFFFC, 1'b0, 32'hFFFFFFFC, "pcinc_wrap_stall");
        pc3 = 32'h20;
        #1;
        expect_out(2'd2, 32'h24, "pc3new");
        pc3 = 32'hFFFFFFFC;
        #1;
        expect_out(2'd2, 32'd0, "pc3new_wrap");

        // Register: reset state, release, capture, mid-cycle reassert
        @(negedge clk);
        expect_out(2'd3, 32'd0, "aluq_reset");
        rst = 1'b0;
        rs1 = 32'd5;
        rs2 = 32'd7;
        alusel = 4'd0;
        #1;
        expect_out(2'd3, 32'd0, "aluq_before_edge");
        @(posedge clk);
        #1;
        expect_out(2'd3, 32'd12, "aluq_capture");
        rs1 = 32'd3;
        rs2 = 32'd5;
        alusel = 4'd1;
        #1;
        expect_out(2'd3, 32'd12, "aluq_hold");
        @(posedge clk);
        #1;
        expect_out(2'd3, 32'hFFFFFFFE, "aluq_capture2");
        #2;
        rst = 1'b1;
        #1;
        expect_out(2'd3, 32'd0, "aluq_async_clear");
        @(posedge clk);
        #1;
        expect_out(2'd3, 32'd0, "aluq_held_reset");
        #1;
        expect_out(2'd0, 32'hFFFFFFFE, "rd_during_reset");

        #2;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_alu_pc_adders.md
# riscv_alu_pc_adders

Execute-side arithmetic cluster of the five-stage RV32I core. Contains the 32-bit ALU (stage 3), the fetch-stage PC incrementer with stall enable (stage 1), and the stage-4 return-address adder (PC+4) that feeds the writeback mux. The outputs ALU result, next-sequential PC and link address are combinational. One registered copy of the ALU result is provided as the EX/MEM ALU value.

## Interface
- No parameters; all datapaths are fixed at 32 bits.
- clk  in  1  core clock; `alu_q` updates on the rising edge.
- rst  in  1  asynchronous, active-high reset; clears `alu_q`.
- rs1  in  32  ALU operand A (rs1 or PC, already muxed).
- rs2  in  32  ALU operand B (rs2 or immediate, already muxed).
- alusel  in  4  ALU operation select.
- rd  out  32  combinational ALU result.
- alu_q  out  32  `rd` registered on `clk`.
- pc  in  32  fetch PC.
- en  in  1  fetch advance enable; 0 means stall.
- pcinc  out  32  next sequential fetch PC.
- pc3  in  32  PC of the instruction in stage 4.
- pc3new  out  32  link value, `pc3 + 4`.

## Operation
- ALU, per `alusel`:
  - 0 ADD: `rs1 + rs2`.
  - 1 SUB: `rs1 - rs2`.
  - 2 SLL: `rs1 << rs2[4:0]`.
  - 3 SLT: signed compare, result `{31'b0, lt}`.
  - 4 SLTU: unsigned compare, result `{31'b0, lt}`.
  - 5 XOR.
  - 6 SRL: logical shift, amount `rs2[4:0]`.
  - 7 SRA: arithmetic shift, amount `rs2[4:0]`.
  - 8 OR.
  - 9 AND.
  - 10 PASSB: `rs2`, used for LUI.
  - 11 MUL: see Configuration.
  - 12–15: result 0.
- Shift amounts use only `rs2[4:0]`; `rs2[31:5]` is ignored.
- All add and subtract results are modulo 2^32. There is no carry or overflow output. 0xFFFFFFFF + 1 = 0.
- PC incrementer:
  - `en`=1: `pcinc = pc + 4`.
  - `en`=0: `pcinc = pc`, so the PC holds.
  - Wraps modulo 2^32: 0xFFFFFFFC + 4 = 0.
- Stage-4 adder: `pc3new = pc3 + 4` always, with the same wrap rule.
- Every combinational output responds to any input change, including X-free behaviour on unknown `alusel` (codes 12–15 return 0).

## Timing
- `rd`, `pcinc`, `pc3new`: zero-cycle combinational paths. They are independent of `clk` and `rst`.
- `alu_q` on each rising `clk` edge:
  - `rst`=0: `alu_q <= rd`.
  - `rst`=1: `alu_q` goes to 0 immediately, asynchronously, and stays 0 while `rst` is held.
- On `rst` deassertion, the first capture happens on the next rising edge.
- Reset values:
  - `alu_q` = 0.
  - Combinational outputs track their inputs during reset; they are not forced.
- `rst` asserted mid-cycle clears `alu_q` without waiting for a clock edge.

## Configuration
- `ALU_MUL_EN` defined: `alusel`=11 returns the low 32 bits of the unsigned product `rs1 * rs2`. This matches RV32M MUL, whose low word is sign-agnostic.
- `ALU_MUL_EN` undefined: no multiplier is instantiated, and `alusel`=11 returns 0 like the other unused codes.

## Test plan
- ADD/SUB wrap:
  - `rs1`=0xFFFFFFFF, `rs2`=1, `alusel`=0 -> `rd`=0.
  - `rs1`=0, `rs2`=1, `alusel`=1 -> `rd`=0xFFFFFFFF.
- Compares with `rs1`=0xFFFFFFFF, `rs2`=1:
  - SLT -> 1.
  - SLTU -> 0.
- Shifts with `rs1`=0x80000000, `rs2`=0x21 (amount 1):
  - SRL -> 0x40000000.
  - SRA -> 0xC0000000.
  - SLL of `rs1`=1 by the same `rs2` -> 2.
- Logic and pass with `rs1`=0xF0F0F0F0, `rs2`=0x0FF00FF0:
  - XOR -> 0xFF00FF00.
  - OR -> 0xFFF0FFF0.
  - AND -> 0x00F000F0.
  - PASSB -> 0x0FF00FF0.
  - `alusel`=14 -> 0.
  - `alusel`=11 -> 0xF0F0F0F0 × 0x0FF00FF0 mod 2^32 with `ALU_MUL_EN`, else 0.
- PC adders:
  - `pc`=0x100, `en`=1 -> `pcinc`=0x104.
  - `pc`=0x100, `en`=0 -> `pcinc`=0x100.
  - `pc`=0xFFFFFFFC, `en`=1 -> `pcinc`=0.
  - `pc3`=0x20 -> `pc3new`=0x24.
- Register and reset:
  - Assert `rst` between edges -> `alu_q`=0 at once.
  - Release `rst` with ADD of 5+7 -> `alu_q`=12 after the next rising edge.
  - Reassert `rst` mid-cycle -> `alu_q`=0 with no edge.
